// File: rtl/flappy_pixel_compositor.sv
// Composites score overlay, bird sprite and pipe layers into 8-bit VGA colour.
// Latency: 2 pix_en-qualified clocks for colour and syncs; hit updates at each frame start.
// Backpressure: none; pix_en low freezes every register and suppresses frame_done.
module flappy_pixel_compositor #(
  parameter int NUM_PIPES = 5,
  parameter int COORD_W = 10,
  parameter int SPR_W = 20,
  parameter int SPR_H = 20,
  parameter logic [SPR_W*SPR_H-1:0] SPR_MASK = '1,
  parameter int FLASH_FRAMES = 8
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           pix_en,
  input  logic [COORD_W-1:0]             CounterX,
  input  logic [COORD_W-1:0]             CounterY,
  input  logic                           inDisplayArea,
  input  logic                           h_sync_in,
  input  logic                           v_sync_in,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x_l,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_x_r,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_y_top,
  input  logic [NUM_PIPES*COORD_W-1:0]   pipe_y_bot,
  input  logic [COORD_W-1:0]             bird_x_l,
  input  logic [COORD_W-1:0]             bird_y_t,
  input  logic                           lose,
  input  logic [3:0]                     score,
  output logic [2:0]                     vga_r,
  output logic [2:0]                     vga_g,
  output logic [1:0]                     vga_b,
  output logic                           vga_h_sync,
  output logic                           vga_v_sync,
  output logic                           hit,
  output logic                           frame_done
);

  localparam int FCW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;
  localparam logic [FCW-1:0] FLASH_LAST = FCW'(FLASH_FRAMES - 1);

  // Score box edges
  localparam logic [COORD_W-1:0] C5   = COORD_W'(5);
  localparam logic [COORD_W-1:0] C10  = COORD_W'(10);
  localparam logic [COORD_W-1:0] C55  = COORD_W'(55);
  localparam logic [COORD_W-1:0] C60  = COORD_W'(60);
  localparam logic [COORD_W-1:0] C105 = COORD_W'(105);
  localparam logic [COORD_W-1:0] C110 = COORD_W'(110);

  logic                   pipe_px, bird_px, ovl_px;
  logic                   frame_start;
  logic [COORD_W:0]       dx, dy;
  int                     col, row;
  logic [SPR_W*SPR_H-1:0] mask_sh;
  logic [6:0]             segs;   // {a,b,c,d,e,f,g}: top, r-up, r-lo, bottom, l-lo, l-up, mid
  logic                   x_lft, x_rgt, x_all, y_up, y_lo, y_top, y_mid, y_bot;

  logic       s1_ovl, s1_bird, s1_pipe, s1_de, s1_hs, s1_vs, s1_fs;
  logic       s1_overlap;
  logic       acc;
  logic       flash;
  logic [FCW-1:0] flash_cnt;

  assign frame_start = pix_en && (CounterX == '0) && (CounterY == '0);

  // Pipe layer: OR of every channel's column minus its gap
  always_comb begin
    pipe_px = 1'b0;
    for (int i = 0; i < NUM_PIPES; i++) begin
      if (CounterX >= pipe_x_l[i*COORD_W +: COORD_W] &&
          CounterX <= pipe_x_r[i*COORD_W +: COORD_W] &&
          (CounterY <= pipe_y_top[i*COORD_W +: COORD_W] ||
           CounterY >= pipe_y_bot[i*COORD_W +: COORD_W]))
        pipe_px = 1'b1;
    end
  end

  // Bird layer: one extra bit on the offsets so left/above of the sprite shows as negative
  always_comb begin
    dx      = {1'b0, CounterX} - {1'b0, bird_x_l};
    dy      = {1'b0, CounterY} - {1'b0, bird_y_t};
    col     = int'(dx);
    row     = int'(dy);
    mask_sh = SPR_MASK >> (row * SPR_W + col);
    bird_px = 1'b0;
    if (!dx[COORD_W] && !dy[COORD_W] && col < SPR_W && row < SPR_H)
      bird_px = mask_sh[0];
  end

  // Score overlay: seven-segment glyph lookup, blank for 10-15
  always_comb begin
    case (score)
      4'd0:    segs = 7'b1111110;
      4'd1:    segs = 7'b0110000;
      4'd2:    segs = 7'b1101101;
      4'd3:    segs = 7'b1111001;
      4'd4:    segs = 7'b0110011;
      4'd5:    segs = 7'b1011011;
      4'd6:    segs = 7'b1011111;
      4'd7:    segs = 7'b1110000;
      4'd8:    segs = 7'b1111111;
      4'd9:    segs = 7'b1111011;
      default: segs = 7'b0000000;
    endcase
    x_lft  = (CounterX >= C5)   && (CounterX <= C10);
    x_rgt  = (CounterX >= C55)  && (CounterX <= C60);
    x_all  = (CounterX >= C5)   && (CounterX <= C60);
    y_up   = (CounterY >= C5)   && (CounterY <= C55);
    y_lo   = (CounterY >= C55)  && (CounterY <= C105);
    y_top  = (CounterY >= C5)   && (CounterY <= C10);
    y_mid  = (CounterY >= C55)  && (CounterY <= C60);
    y_bot  = (CounterY >= C105) && (CounterY <= C110);
    ovl_px = (segs[6] && x_all && y_top) ||
             (segs[5] && x_rgt && y_up)  ||
             (segs[4] && x_rgt && y_lo)  ||
             (segs[3] && x_all && y_bot) ||
             (segs[2] && x_lft && y_lo)  ||
             (segs[1] && x_lft && y_up)  ||
             (segs[0] && x_all && y_mid);
  end

  // Stage 1: capture layer flags, display qualifier, syncs and frame-start marker
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_ovl  <= 1'b0;
      s1_bird <= 1'b0;
      s1_pipe <= 1'b0;
      s1_de   <= 1'b0;
      s1_fs   <= 1'b0;
      s1_hs   <= 1'b1;
      s1_vs   <= 1'b1;
    end else if (pix_en) begin
      s1_ovl  <= ovl_px;
      s1_bird <= bird_px;
      s1_pipe <= pipe_px;
      s1_de   <= inDisplayArea;
      s1_fs   <= frame_start;
      s1_hs   <= h_sync_in;
      s1_vs   <= v_sync_in;
    end
  end

  // Stage 2: priority colour mux, blanked outside the display area
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vga_r      <= 3'd0;
      vga_g      <= 3'd0;
      vga_b      <= 2'd0;
      vga_h_sync <= 1'b1;
      vga_v_sync <= 1'b1;
    end else if (pix_en) begin
      vga_h_sync <= s1_hs;
      vga_v_sync <= s1_vs;
      if (!s1_de) begin
        vga_r <= 3'd0; vga_g <= 3'd0; vga_b <= 2'd0;
      end else if (s1_ovl) begin
        vga_r <= 3'd7; vga_g <= 3'd7; vga_b <= 2'd3;
      end else if (s1_bird) begin
        vga_r <= 3'd7; vga_g <= 3'd0; vga_b <= 2'd0;
      end else if (s1_pipe) begin
        vga_r <= 3'd0; vga_g <= 3'd7; vga_b <= 2'd0;
      end else begin
        vga_r <= 3'd0; vga_g <= 3'd0; vga_b <= flash ? 2'd3 : 2'd0;
      end
    end
  end

  // Background flash while lost; cleared on the next clock once lose drops
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (!lose) begin
      flash     <= 1'b0;
      flash_cnt <= '0;
    end else if (frame_start) begin
      if (flash_cnt == FLASH_LAST) begin
        flash_cnt <= '0;
        flash     <= ~flash;
      end else begin
        flash_cnt <= flash_cnt + 1'b1;
      end
    end
  end

  // The frame-start pixel is credited to the closing frame directly from stage 0,
  // so its stage-1 copy is kept out of the new frame's accumulator.
  assign s1_overlap = s1_bird && s1_pipe && s1_de && !s1_fs;

  // Collision accumulator: close the frame into hit and pulse frame_done at frame start
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc        <= 1'b0;
      hit        <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (frame_start) begin
        hit        <= acc || s1_overlap || (bird_px && pipe_px && inDisplayArea);
        acc        <= 1'b0;
        frame_done <= 1'b1;
      end else if (pix_en) begin
        acc <= acc || s1_overlap;
      end
    end
  end

endmodule

// File: tb/tb_flappy_pixel_compositor.sv
// Directed bench for flappy_pixel_compositor: 8 pipe channels, 2-frame flash,
// sprite mask with bit 0 (top-left pixel) transparent.
module tb_flappy_pixel_compositor;

  localparam int NP = 8;
  localparam int CW = 10;
  localparam logic [399:0] MASK = ~400'd1;

  localparam logic [7:0] BLACK = 8'b000_000_00;
  localparam logic [7:0] WHITE = 8'b111_111_11;
  localparam logic [7:0] RED   = 8'b111_000_00;
  localparam logic [7:0] GREEN = 8'b000_111_00;
  localparam logic [7:0] BLUE  = 8'b000_000_11;

  logic             clk = 1'b0;
  logic             reset;
  logic             pix_en;
  logic [CW-1:0]    CounterX, CounterY;
  logic             inDisplayArea, h_sync_in, v_sync_in;
  logic [NP*CW-1:0] pipe_x_l, pipe_x_r, pipe_y_top, pipe_y_bot;
  logic [CW-1:0]    bird_x_l, bird_y_t;
  logic             lose;
  logic [3:0]       score;
  logic [2:0]       vga_r, vga_g;
  logic [1:0]       vga_b;
  logic             vga_h_sync, vga_v_sync, hit, frame_done;

  int n_chk = 0;
  int n_fail = 0;

  flappy_pixel_compositor #(
    .NUM_PIPES(NP), .COORD_W(CW), .SPR_W(20), .SPR_H(20),
    .SPR_MASK(MASK), .FLASH_FRAMES(2)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en),
    .CounterX(CounterX), .CounterY(CounterY), .inDisplayArea(inDisplayArea),
    .h_sync_in(h_sync_in), .v_sync_in(v_sync_in),
    .pipe_x_l(pipe_x_l), .pipe_x_r(pipe_x_r), .pipe_y_top(pipe_y_top), .pipe_y_bot(pipe_y_bot),
    .bird_x_l(bird_x_l), .bird_y_t(bird_y_t), .lose(lose), .score(score),
    .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
    .vga_h_sync(vga_h_sync), .vga_v_sync(vga_v_sync),
    .hit(hit), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, want $finish");
    $fatal(1, "watchdog expired");
  end

  task automatic set_pipe(input int ch, input int xl, input int xr, input int yt, input int yb);
    pipe_x_l[ch*CW +: CW]   = CW'(xl);
    pipe_x_r[ch*CW +: CW]   = CW'(xr);
    pipe_y_top[ch*CW +: CW] = CW'(yt);
    pipe_y_bot[ch*CW +: CW] = CW'(yb);
  endtask

  // Present one pixel for one clock, then sample 1 time unit after the edge
  task automatic tick(input int x, input int y, input logic de, input logic en);
    CounterX      = CW'(x);
    CounterY      = CW'(y);
    inDisplayArea = de;
    pix_en        = en;
    @(posedge clk);
    #1;
  endtask

  // Hold a pixel for two enabled clocks so the outputs show that same pixel
  task automatic show(input int x, input int y);
    tick(x, y, 1'b1, 1'b1);
    tick(x, y, 1'b1, 1'b1);
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL reset_colour: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    n_chk++; if ({vga_h_sync, vga_v_sync} !== 2'b11) begin n_fail++; $display("FAIL reset_syncs: got %b want 11", {vga_h_sync, vga_v_sync}); end
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL reset_hit: got %b want 0", hit); end
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done: got %b want 0", frame_done); end
    reset = 1'b0;
  endtask

  task automatic test_bird_pipe;
    bird_x_l = 10'd100; bird_y_t = 10'd200;
    set_pipe(0, 110, 150, 150, 250);
    set_pipe(7, 110, 115, 205, 1023);
    tick(0, 0, 1'b1, 1'b1);
    tick(105, 210, 1'b1, 1'b1);
    tick(115, 100, 1'b1, 1'b1);
    n_chk++; if ({vga_r, vga_g, vga_b} !== RED) begin n_fail++; $display("FAIL bird_105_210: got %b want %b", {vga_r, vga_g, vga_b}, RED); end
    tick(112, 203, 1'b1, 1'b1);
    n_chk++; if ({vga_r, vga_g, vga_b} !== GREEN) begin n_fail++; $display("FAIL pipe_115_100: got %b want %b", {vga_r, vga_g, vga_b}, GREEN); end
    tick(300, 400, 1'b1, 1'b1);
    n_chk++; if ({vga_r, vga_g, vga_b} !== RED) begin n_fail++; $display("FAIL bird_over_pipe7: got %b want %b", {vga_r, vga_g, vga_b}, RED); end
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL hit_before_close: got %b want 0", hit); end
    show(113, 180);
    n_chk++; if ({vga_r, vga_g, vga_b} !== GREEN) begin n_fail++; $display("FAIL pipe7_drawn: got %b want %b", {vga_r, vga_g, vga_b}, GREEN); end
    tick(105, 210, 1'b0, 1'b1);
    tick(105, 210, 1'b0, 1'b1);
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL blank_outside_display: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    tick(0, 0, 1'b1, 1'b1);
    n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_at_frame_start: got %b want 1", hit); end
    n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL frame_done_pulse: got %b want 1", frame_done); end
    tick(400, 400, 1'b1, 1'b1);
    n_chk++; if (frame_done !== 1'b0) begin n_fail++; $display("FAIL frame_done_one_clk: got %b want 0", frame_done); end
    n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL hit_holds: got %b want 1", hit); end
  endtask

  task automatic test_no_hit;
    int px[6];
    int py[6];
    logic [7:0] ec[6];
    bird_x_l = 10'd300; bird_y_t = 10'd200;
    for (int c = 0; c < NP; c++) set_pipe(c, 600, 620, 150, 250);
    px = '{300, 305, 610, 610, 320, 299};
    py = '{200, 205, 100, 300, 205, 205};
    ec = '{BLACK, RED, GREEN, GREEN, BLACK, BLACK};
    tick(0, 0, 1'b1, 1'b1);
    for (int k = 0; k < 6; k++) begin
      show(px[k], py[k]);
      n_chk++;
      if ({vga_r, vga_g, vga_b} !== ec[k]) begin
        n_fail++;
        $display("FAIL no_hit_px_%0d_%0d: got %b want %b", px[k], py[k], {vga_r, vga_g, vga_b}, ec[k]);
      end
    end
    tick(0, 0, 1'b1, 1'b1);
    n_chk++; if (hit !== 1'b0) begin n_fail++; $display("FAIL no_hit_frame: got %b want 0", hit); end
    n_chk++; if (frame_done !== 1'b1) begin n_fail++; $display("FAIL no_hit_frame_done: got %b want 1", frame_done); end
  endtask

  task automatic test_score;
    int px[7];
    int py[7];
    score = 4'd7;
    show(57, 30);
    n_chk++; if ({vga_r, vga_g, vga_b} !== WHITE) begin n_fail++; $display("FAIL score7_right_upper: got %b want %b", {vga_r, vga_g, vga_b}, WHITE); end
    show(7, 30);
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL score7_left_upper: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    show(60, 55);
    n_chk++; if ({vga_r, vga_g, vga_b} !== WHITE) begin n_fail++; $display("FAIL score7_seg_corner: got %b want %b", {vga_r, vga_g, vga_b}, WHITE); end
    score = 4'd0;
    show(30, 57);
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL score0_mid: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    show(7, 80);
    n_chk++; if ({vga_r, vga_g, vga_b} !== WHITE) begin n_fail++; $display("FAIL score0_left_lower: got %b want %b", {vga_r, vga_g, vga_b}, WHITE); end
    score = 4'd8;
    show(30, 57);
    n_chk++; if ({vga_r, vga_g, vga_b} !== WHITE) begin n_fail++; $display("FAIL score8_mid: got %b want %b", {vga_r, vga_g, vga_b}, WHITE); end
    score = 4'd12;
    px = '{7, 57, 30, 30, 30, 7, 57};
    py = '{30, 30, 7, 57, 107, 80, 80};
    for (int k = 0; k < 7; k++) begin
      show(px[k], py[k]);
      n_chk++;
      if ({vga_r, vga_g, vga_b} !== BLACK) begin
        n_fail++;
        $display("FAIL score12_blank_%0d_%0d: got %b want %b", px[k], py[k], {vga_r, vga_g, vga_b}, BLACK);
      end
    end
    score = 4'd15;
  endtask

  task automatic test_flash;
    logic [7:0] eb[6];
    eb = '{BLACK, BLUE, BLUE, BLACK, BLACK, BLUE};
    lose = 1'b1;
    for (int k = 0; k < 6; k++) begin
      tick(0, 0, 1'b1, 1'b1);
      show(400, 400);
      n_chk++;
      if ({vga_r, vga_g, vga_b} !== eb[k]) begin
        n_fail++;
        $display("FAIL flash_frame_%0d: got %b want %b", k + 1, {vga_r, vga_g, vga_b}, eb[k]);
      end
    end
    show(305, 205);
    n_chk++; if ({vga_r, vga_g, vga_b} !== RED) begin n_fail++; $display("FAIL flash_bird_priority: got %b want %b", {vga_r, vga_g, vga_b}, RED); end
    lose = 1'b0;
    show(400, 400);
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL flash_clear: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    tick(0, 0, 1'b1, 1'b1);
    show(400, 400);
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL flash_stays_clear: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
  endtask

  task automatic test_back_to_back_gated;
    int px[6];
    int py[6];
    logic hs[6];
    logic vs[6];
    logic [7:0] ec[6];
    score = 4'd7;
    px = '{400, 305, 610, 400, 57, 610};
    py = '{400, 205, 100, 400, 30, 300};
    hs = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    vs = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    ec = '{BLACK, RED, GREEN, BLACK, WHITE, GREEN};
    for (int n = 0; n < 6; n++) begin
      h_sync_in = hs[n];
      v_sync_in = vs[n];
      tick(px[n], py[n], 1'b1, 1'b1);
      if (n >= 1) begin
        n_chk++;
        if ({vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync} !== {ec[n-1], hs[n-1], vs[n-1]}) begin
          n_fail++;
          $display("FAIL gated_lag_%0d: got %b want %b", n, {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync}, {ec[n-1], hs[n-1], vs[n-1]});
        end
      end
      h_sync_in = ~hs[n];
      v_sync_in = ~vs[n];
      repeat (3) tick(0, 0, 1'b0, 1'b0);
      if (n >= 1) begin
        n_chk++;
        if ({vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_done} !== {ec[n-1], hs[n-1], vs[n-1], 1'b0}) begin
          n_fail++;
          $display("FAIL gated_hold_%0d: got %b want %b", n, {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync, frame_done}, {ec[n-1], hs[n-1], vs[n-1], 1'b0});
        end
      end
    end
    tick(400, 400, 1'b1, 1'b1);
    n_chk++;
    if ({vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync} !== {ec[5], hs[5], vs[5]}) begin
      n_fail++;
      $display("FAIL gated_lag_last: got %b want %b", {vga_r, vga_g, vga_b, vga_h_sync, vga_v_sync}, {ec[5], hs[5], vs[5]});
    end
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    score = 4'd15;
  endtask

  task automatic test_reset_mid_frame;
    set_pipe(7, 300, 310, 205, 1023);
    tick(0, 0, 1'b1, 1'b1);
    tick(305, 203, 1'b1, 1'b1);
    tick(400, 400, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1);
    n_chk++; if (hit !== 1'b1) begin n_fail++; $display("FAIL overlap_before_reset: got %b want 1", hit); end
    tick(305, 203, 1'b1, 1'b1);
    tick(400, 400, 1'b1, 1'b1);
    n_chk++; if ({vga_r, vga_g, vga_b} !== RED) begin n_fail++; $display("FAIL red_before_reset: got %b want %b", {vga_r, vga_g, vga_b}, RED); end
    #2 reset = 1'b1;
    #1;
    n_chk++; if ({vga_r, vga_g, vga_b} !== BLACK) begin n_fail++; $display("FAIL async_reset_colour: got %b want %b", {vga_r, vga_g, vga_b}, BLACK); end
    n_chk++; if ({vga_h_sync, vga_v_sync} !== 2'b11) begin n_fail++; $display("FAIL async_reset_syncs: got %b want 11", {vga_h_sync, vga_v_sync}); end
    n_chk++; if ({hit, frame_done} !== 2'b00) begin n_fail++; $display("FAIL async_reset_hit: got %b want 00", {hit, frame_done}); end
    @(posedge clk);
    #1 reset = 1'b0;
    tick(400, 400, 1'b1, 1'b1);
    tick(0, 0, 1'b1, 1'b1);
    n_chk++; if ({hit, frame_done} !== 2'b01) begin n_fail++; $display("FAIL hit_after_reset: got %b want 01", {hit, frame_done}); end
  endtask

  initial begin
    reset = 1'b1;
    pix_en = 1'b0;
    CounterX = '0;
    CounterY = '0;
    inDisplayArea = 1'b0;
    h_sync_in = 1'b1;
    v_sync_in = 1'b1;
    bird_x_l = 10'd100;
    bird_y_t = 10'd200;
    lose = 1'b0;
    score = 4'd15;
    pipe_x_l = '0;
    pipe_x_r = '0;
    pipe_y_top = '0;
    pipe_y_bot = '0;
    for (int c = 0; c < NP; c++) set_pipe(c, 1000, 1010, 0, 1023);

    test_reset;
    test_bird_pipe;
    test_no_hit;
    test_score;
    test_flash;
    test_back_to_back_gated;
    test_reset_mid_frame;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/flappy_pixel_compositor.md
FLAPPY_PIXEL_COMPOSITOR -- requirements
Module: flappy_pixel_compositor

Parameters
REQ-001 SHALL have parameter NUM_PIPES, default 5: number of pipe channels composited, legal range 1-8.
REQ-002 SHALL have parameter COORD_W, default 10: width of every pixel coordinate.
REQ-003 SHALL have parameter SPR_W / SPR_H, default 20 / 20: bird sprite width and height in pixels.
REQ-004 SHALL have parameter SPR_MASK, default all ones, width SPR_W*SPR_H: sprite bitmap; bit (row*SPR_W+col) set means opaque; row 0 is top, col 0 is left.
REQ-005 SHALL have parameter FLASH_FRAMES, default 8: number of frames per flash half-period while lost.

Interface
REQ-006 SHALL have port clk, input, 1 bit: the single system clock; all state changes on its rising edge.
REQ-007 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-008 SHALL have port pix_en, input, 1 bit: pixel-rate enable; pipeline and all counters advance only when it is 1.
REQ-009 SHALL have ports CounterX and CounterY, input, COORD_W bits each: current raster position.
REQ-010 SHALL have port inDisplayArea, input, 1 bit: visible-pixel qualifier.
REQ-011 SHALL have port h_sync_in / v_sync_in, input, 1 bit each: raw sync signals.
REQ-012 SHALL have ports pipe_x_l, pipe_x_r, pipe_y_top and pipe_y_bot, input, NUM_PIPES*COORD_W bits each: packed pipe edges; channel i occupies bits [i*COORD_W +: COORD_W].
REQ-013 SHALL have ports bird_x_l and bird_y_t, input, COORD_W bits each: sprite top-left corner.
REQ-014 SHALL have port lose, input, 1 bit: game-over level.
REQ-015 SHALL have port score, input, 4 bits: score digit for the on-screen overlay.
REQ-016 SHALL have ports vga_r [2:0], vga_g [2:0], vga_b [1:0], output: registered colour.
REQ-017 SHALL have ports vga_h_sync / vga_v_sync, output, 1 bit each: sync signals delayed to align with colour.
REQ-018 SHALL have port hit, output, 1 bit: previous frame contained at least one bird/pipe pixel overlap.
REQ-019 SHALL have port frame_done, output, 1 bit: one-clk pulse when hit updates.

Function
REQ-020 Pipe pixel, channel i, SHALL be true when x_l <= X <= x_r and (Y <= y_top or Y >= y_bot); the pipe layer is the OR over all channels.
REQ-021 Bird pixel SHALL be true when 0 <= X-bird_x_l < SPR_W, 0 <= Y-bird_y_t < SPR_H, and the corresponding mask bit is 1.
- Subtraction SHALL be computed at COORD_W+1 bits so X < bird_x_l never aliases into the sprite.
REQ-022 Score overlay SHALL draw 7-segment digit `score` in the box x 5..60, y 5..110.
- Segments: left-upper x5-10/y5-55; left-lower x5-10/y55-105; right-upper x55-60/y5-55; right-lower x55-60/y55-105; top x5-60/y5-10; mid x5-60/y55-60; bottom x5-60/y105-110.
- Values 0-9 use standard glyphs; 10-15 SHALL draw nothing.
REQ-023 Pipeline SHALL have 2 stages.
- Stage 1 registers the layer flags (overlay, bird, pipe) plus inDisplayArea and the syncs.
- Stage 2 registers the colour.
- Latency SHALL be exactly 2 pix_en-qualified clocks; vga_h_sync / vga_v_sync SHALL see the same delay.
REQ-024 Colour priority SHALL be:
- overlay: r=7, g=7, b=3;
- else bird: r=7, g=0, b=0;
- else pipe: r=0, g=7, b=0;
- else background: r=0, g=0, b=(flash ? 3 : 0).
- All outputs SHALL be 0 when the delayed inDisplayArea is 0.
REQ-025 Frame start SHALL be pix_en and CounterX==0 and CounterY==0.
REQ-026 Flash SHALL work as follows.
- While lose=1: a frame counter increments at each frame start; at FLASH_FRAMES-1 it wraps to 0 and toggles flash.
- While lose=0: counter=0 and flash=0, from the next clk.
REQ-027 Collision accumulator SHALL set when a stage-1 pixel has bird, pipe and display all true.
- At frame start: hit <= acc | current-pixel overlap, acc is cleared, and frame_done pulses for 1 clk.
- An overlap on the frame-start pixel itself SHALL count toward the closing frame.
REQ-028 When pix_en=0, all registers SHALL hold their value, and frame_done SHALL be 0.

Reset
REQ-029 While reset=1, asynchronously:
- vga_r, vga_g, vga_b = 0;
- syncs = 1;
- hit = 0, frame_done = 0;
- flash, frame counter, accumulator and pipeline flags = 0.
REQ-030 Reset asserted mid-frame SHALL discard partial accumulation; the first hit after release SHALL reflect only pixels seen after release.

Verification
REQ-031 Bird at (100,200), pipe0 x 110..150 with gap 150..250, pix_en=1, raster stepped: at (105,210) colour r=7,g=0,b=0 two clocks later; at (115,100) g=7; at (0,0) of the next frame hit=1 and frame_done pulses once.
REQ-032 Bird at (300,200), all pipes at x 600..620: after a full frame, hit=0; SPR_MASK bit 0 cleared gives colour 0 at (300,200).
REQ-033 score=7, pixel (57,30) -> white; pixel (7,30) -> background; score=12 -> no white anywhere in the box.
REQ-034 lose=1 with FLASH_FRAMES=2: b toggles 0->3->0 every 2 frames on background pixels; lose=0 -> b=0 from the next frame on.
REQ-035 Toggle pix_en 1-of-4 cycles: colour and syncs still lag exactly 2 enabled cycles; reset pulsed mid-frame -> all outputs 0 (syncs 1) immediately, hit=0 after release.
REQ-036 NUM_PIPES=8: a pipe placed only in channel 7 is drawn and detected by the collision logic.
